// File: rtl/antitheft_timer.sv
// -----------------------------------------------------------------------------
// antitheft_timer
//
// Timing companion to the anti-theft control FSM. Holds four programmable
// delay values (seconds), divides the system clock down to a 1 Hz tick and
// runs a per-second countdown on request from the FSM.
//
// Build option:
//   FAST_TICK_EN  when defined, the divider period is 16 cycles regardless of
//                 CLK_FREQ (simulation / slow-clock demo). When undefined, the
//                 divider period is CLK_FREQ cycles.
//
// Ports:
//   clock           system clock
//   reset           asynchronous, active-high reset
//   start_timer     level from the FSM; high requests a countdown
//   interval        selects which delay register to count (00..11)
//   reprogram       write strobe for the delay registers
//   time_param_sel  delay register to write
//   time_value      value to write, in seconds
//   expired         one-cycle pulse when the countdown reaches zero
//   one_hz_enable   one-cycle pulse once per divider period
// -----------------------------------------------------------------------------
module antitheft_timer #(
  parameter int unsigned CLK_FREQ    = 50000000,
  parameter logic [3:0]  T_ARM       = 4'd6,
  parameter logic [3:0]  T_DRIVER    = 4'd8,
  parameter logic [3:0]  T_PASSENGER = 4'd15,
  parameter logic [3:0]  T_ALARM     = 4'd10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_timer,
  input  logic [1:0] interval,
  input  logic       reprogram,
  input  logic [1:0] time_param_sel,
  input  logic [3:0] time_value,
  output logic       expired,
  output logic       one_hz_enable
);

`ifdef FAST_TICK_EN
  localparam int unsigned DIV = 16;
`else
  localparam int unsigned DIV = CLK_FREQ;
`endif

  localparam int unsigned   DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StLoad  = 2'b01,
    StCount = 2'b10,
    StDone  = 2'b11
  } state_t;

  state_t           state_q;
  logic [DIV_W-1:0] divider_q;
  logic [3:0]       count_q;
  logic [1:0]       cur_interval_q;
  logic [3:0]       delay_q [4];
  logic             tick;

  // Terminal count of the divider; the registered one_hz_enable follows it.
  assign tick = (divider_q == DIV_LAST);

  // ---------------------------------------------------------------------------
  // Delay registers. LOAD reads delay_q on the same edge a write may land, so
  // a coincident write is seen only by the following LOAD.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      delay_q[0] <= T_ARM;
      delay_q[1] <= T_DRIVER;
      delay_q[2] <= T_PASSENGER;
      delay_q[3] <= T_ALARM;
    end else if (reprogram) begin
      delay_q[time_param_sel] <= time_value;
    end
  end

  // ---------------------------------------------------------------------------
  // Divider, countdown and control FSM with registered outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      divider_q      <= '0;
      count_q        <= 4'd0;
      cur_interval_q <= 2'b00;
      expired        <= 1'b0;
      one_hz_enable  <= 1'b0;
    end else begin
      expired       <= 1'b0;
      one_hz_enable <= tick;

      // Free-running divider; LOAD overrides this below so every counted
      // second starts from a full period.
      if (tick) begin
        divider_q <= '0;
      end else begin
        divider_q <= divider_q + DIV_W'(1);
      end

      unique case (state_q)
        StIdle: begin
          if (start_timer) begin
            cur_interval_q <= interval;
            state_q        <= StLoad;
          end
        end

        StLoad: begin
          count_q   <= delay_q[cur_interval_q];
          divider_q <= '0;
          state_q   <= StCount;
        end

        StCount: begin
          if (!start_timer) begin
            // Abort: no expired pulse.
            state_q <= StIdle;
          end else if (interval != cur_interval_q) begin
            cur_interval_q <= interval;
            state_q        <= StLoad;
          end else if (count_q == 4'd0) begin
            // Zero-length delay fires without waiting for a tick.
            expired <= 1'b1;
            state_q <= StDone;
          end else if (tick) begin
            if (count_q == 4'd1) begin
              count_q <= 4'd0;
              expired <= 1'b1;
              state_q <= StDone;
            end else begin
              count_q <= count_q - 4'd1;
            end
          end
        end

        StDone: begin
          // Hold until the FSM drops the request or picks a new interval.
          if (!start_timer) begin
            state_q <= StIdle;
          end else if (interval != cur_interval_q) begin
            cur_interval_q <= interval;
            state_q        <= StLoad;
          end
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  // expired is a single-cycle pulse and is only raised on entry to DONE.
  assert property (@(posedge clock) disable iff (reset) expired |=> !expired);
  assert property (@(posedge clock) disable iff (reset) expired |-> (state_q == StDone));
`endif

endmodule

// File: tb/tb_antitheft_timer.sv
// -----------------------------------------------------------------------------
// Bench for antitheft_timer. CLK_FREQ is set to 16 so the divider period is
// 16 cycles in either build. Stimulus pushes the absolute cycle at which each
// expired pulse (and, in one window, each one_hz_enable pulse) must appear;
// a negedge monitor pops and compares whenever the DUT raises the output.
// -----------------------------------------------------------------------------
module tb_antitheft_timer;

  localparam int DIV = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start_timer = 1'b0;
  logic [1:0] interval = 2'b00;
  logic       reprogram = 1'b0;
  logic [1:0] time_param_sel = 2'b00;
  logic [3:0] time_value = 4'd0;
  logic       expired;
  logic       one_hz_enable;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int e0 = 0;
  int exp_q[$];
  int hz_q[$];
  int hz_lo = -1;
  int hz_hi = -1;

  antitheft_timer #(
    .CLK_FREQ   (16),
    .T_ARM      (4'd6),
    .T_DRIVER   (4'd8),
    .T_PASSENGER(4'd15),
    .T_ALARM    (4'd10)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .start_timer   (start_timer),
    .interval      (interval),
    .reprogram     (reprogram),
    .time_param_sel(time_param_sel),
    .time_value    (time_value),
    .expired       (expired),
    .one_hz_enable (one_hz_enable)
  );

  always #5 clock = ~clock;

  // Edge index: after posedge k, cyc == k.
  always @(posedge clock) cyc <= cyc + 1;

  function automatic void check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, wanted %0d (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Monitor: compare every output pulse against the scoreboard.
  always @(negedge clock) begin
    int e;
    if (!reset) begin
      if (expired) begin
        if (exp_q.size() == 0) begin
          check("unexpected_expired_at_cycle", cyc, -1);
        end else begin
          e = exp_q.pop_front();
          check("expired_cycle", cyc, e);
        end
      end
      if (one_hz_enable && cyc >= hz_lo && cyc <= hz_hi) begin
        if (hz_q.size() == 0) begin
          check("unexpected_one_hz_at_cycle", cyc, -1);
        end else begin
          e = hz_q.pop_front();
          check("one_hz_cycle", cyc, e);
        end
      end
    end
  end

  // Raise start_timer; n >= 0 pushes the expected expiry, n < 0 pushes none.
  task automatic start_run(input logic [1:0] iv, input int n);
    @(negedge clock);
    start_timer = 1'b1;
    interval    = iv;
    e0          = cyc + 1;
    if (n == 0)      exp_q.push_back(e0 + 2);
    else if (n > 0)  exp_q.push_back(e0 + 1 + n * DIV);
  endtask

  task automatic drain(input string name, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clock);
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic stop_run();
    @(negedge clock);
    start_timer = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic program_reg(input logic [1:0] sel, input logic [3:0] val);
    @(negedge clock);
    reprogram      = 1'b1;
    time_param_sel = sel;
    time_value     = val;
    @(negedge clock);
    reprogram = 1'b0;
  endtask

  initial begin
    int c;
    #200000;
    $display("FAIL watchdog: got timeout, wanted completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    // Reset state.
    repeat (3) @(negedge clock);
    check("reset_expired", int'(expired), 0);
    check("reset_one_hz", int'(one_hz_enable), 0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // 1: driver delay 8 -> E0+129, one_hz every 16 cycles from LOAD.
    start_run(2'b01, 8);
    hz_lo = e0 + 2;
    hz_hi = e0 + 1 + 8 * DIV;
    for (int k = 1; k <= 8; k++) hz_q.push_back(e0 + 1 + k * DIV);
    drain("t1_expired_pending", 200);
    repeat (20) @(negedge clock);
    check("t1_one_hz_pending", hz_q.size(), 0);
    hz_lo = -1;
    hz_hi = -1;
    stop_run();

    // 2: passenger reprogrammed to 3 -> E0+49.
    program_reg(2'b10, 4'd3);
    start_run(2'b10, 3);
    drain("t2_expired_pending", 100);
    repeat (10) @(negedge clock);
    stop_run();

    // Write landing on the LOAD edge: old value 6 used, new value 2 next time.
    @(negedge clock);
    start_timer = 1'b1;
    interval    = 2'b00;
    e0          = cyc + 1;
    exp_q.push_back(e0 + 1 + 6 * DIV);
    @(negedge clock);
    reprogram      = 1'b1;
    time_param_sel = 2'b00;
    time_value     = 4'd2;
    @(negedge clock);
    reprogram = 1'b0;
    drain("t7_old_value_pending", 150);
    stop_run();
    start_run(2'b00, 2);
    drain("t7_new_value_pending", 80);
    stop_run();
    program_reg(2'b00, 4'd6);

    // 3: abort after 40 cycles, then full restart -> E0+97.
    start_run(2'b00, -1);
    repeat (40) @(negedge clock);
    stop_run();
    repeat (150) @(negedge clock);
    start_run(2'b00, 6);
    drain("t3_restart_pending", 150);
    stop_run();

    // 4: switch 01 -> 11 mid-count; reload 10 -> change edge + 161.
    start_run(2'b01, -1);
    repeat (49) @(negedge clock);
    interval = 2'b11;
    c = cyc + 1;
    exp_q.push_back(c + 1 + 10 * DIV);
    drain("t4_switch_pending", 250);
    repeat (30) @(negedge clock);
    stop_run();

    // 5: zero delay -> E0+2, held in DONE without re-fire.
    program_reg(2'b01, 4'd0);
    start_run(2'b01, 0);
    drain("t5_zero_pending", 10);
    repeat (40) @(negedge clock);
    stop_run();

    // 6: reset with count == 5 while one_hz_enable is high.
    start_run(2'b00, -1);
    repeat (18) @(negedge clock);
    check("t6_one_hz_before_reset", int'(one_hz_enable), 1);
    reset       = 1'b1;
    start_timer = 1'b0;
    #1;
    check("t6_expired_in_reset", int'(expired), 0);
    check("t6_one_hz_in_reset", int'(one_hz_enable), 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    start_run(2'b10, 15);
    drain("t6_passenger_default_pending", 300);
    stop_run();
    start_run(2'b01, 8);
    drain("t6_driver_default_pending", 200);
    stop_run();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/antitheft_timer.md
Name: antitheft_timer

Overview:
- Timing companion to the anti-theft control FSM.
- Receives `start_timer` and `interval[1:0]` from the FSM. Returns `expired` and the `one_hz_enable` tick the FSM uses for status blinking.
- Holds four user-programmable delay values, written through the reprogram interface.
- Contains the 1 Hz divider and a per-second countdown.

Parameters:
- CLK_FREQ, 50000000, clock frequency in Hz; the divider terminal count is CLK_FREQ-1.
- T_ARM, 4'd6, reset value of the arming delay in seconds (interval 00).
- T_DRIVER, 4'd8, reset value of the driver-door delay (interval 01).
- T_PASSENGER, 4'd15, reset value of the passenger-door delay (interval 10).
- T_ALARM, 4'd10, reset value of the siren-on time (interval 11).

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- start_timer  input  1  level from FSM; high requests a countdown
- interval  input  2  selects the delay register to count
- reprogram  input  1  write strobe for the delay registers
- time_param_sel  input  2  delay register to write
- time_value  input  4  value to write, in seconds
- expired  output  1  one-cycle pulse when the countdown reaches 0
- one_hz_enable  output  1  one-cycle pulse once per second

Behaviour:
- Reset (async, active-high) values:
  - expired=0, one_hz_enable=0.
  - State IDLE; divider=0; count=0; cur_interval=00.
  - Delay registers = T_ARM, T_DRIVER, T_PASSENGER, T_ALARM.
- Delay registers:
  - A clock edge with reprogram=1 writes time_value into register[time_param_sel].
  - The write is visible to the next LOAD only; a countdown in progress is unaffected.
- Divider:
  - Counts 0..DIV-1 and wraps. DIV = CLK_FREQ.
  - one_hz_enable (registered) pulses for one cycle on each wrap.
  - The divider is cleared in LOAD, so every counted second is exactly DIV cycles.
  - In all other states the divider is free-running.
- State IDLE:
  - start_timer=1 → LOAD, and cur_interval<=interval.
  - Otherwise stay.
- State LOAD (one cycle):
  - count<=register[cur_interval]; divider<=0; → COUNT.
- State COUNT, priority in this order:
  1. start_timer=0 → IDLE. Abort; no expired pulse.
  2. interval≠cur_interval → LOAD, and cur_interval<=interval.
  3. count==0 → expired<=1, → DONE.
  4. Tick with count==1 → count<=0, expired<=1, → DONE.
  5. Tick with count>1 → count<=count-1.
- State DONE (expired already deasserted):
  - start_timer=0 → IDLE.
  - interval change → LOAD, and cur_interval<=interval.
  - Otherwise hold. No re-fire while start_timer stays high with the same interval.
- Latency: let E0 be the first edge at which start_timer=1 is sampled in IDLE.
  - expired rises at edge E0+1+N·DIV, where N is the loaded value.
  - For N=0, expired rises at E0+2.
- expired is exactly one cycle wide.
- A reprogram write and a LOAD on the same edge: LOAD captures the old value.
- Unused state encodings → IDLE.

Optional Feature:
- Macro: FAST_TICK_EN.
- Defined: DIV=16, independent of CLK_FREQ. Used for simulation and for the protoboard demo with a slow clock.
- Undefined: DIV=CLK_FREQ.
- All other behaviour is identical in both builds.

Test Plan (all with FAST_TICK_EN, DIV=16):
1. Reset, then start_timer=1, interval=01 → expired pulses once at E0+129 (8·16+1); one_hz_enable pulses every 16 cycles.
2. reprogram=1, time_param_sel=10, time_value=3 for one cycle, then start with interval=10 → expired at E0+49; a later reset restores T_PASSENGER=15.
3. Start with interval=00, drop start_timer after 40 cycles → no expired pulse; state IDLE; a restart gives expired at the full E0+97.
4. Count with interval=01 for 50 cycles, then switch interval to 11 with start held → reload of 10; expired 1+160 edges after the change edge; a single pulse only.
5. Program register 01 with 0, start with interval=01 → expired at E0+2; held in DONE with no second pulse while start_timer stays high.
6. Assert reset mid-countdown (count=5) → expired=0 and one_hz_enable=0 immediately; state IDLE; registers back to defaults.
